deserializador_trama: RTL and testbench
=======================================

DESERIALIZADOR_TRAMA -- requirements
Module: deserializador_trama

Interface
REQ-001 SHALL have parameter ANCHO, default 5, payload word width in bits.
REQ-002 SHALL have parameter PROFUNDIDAD, default 4, output FIFO depth in words, power of two.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_in  input  1  serial bit stream, MSB first, sampled on rising clk.
REQ-006 SHALL have port valido  input  1  synchronization flag from the upstream sequence detector; high while the link is in sync.
REQ-007 SHALL have port dato_out  output  ANCHO  head-of-FIFO payload word.
REQ-008 SHALL have port dato_valido  output  1  high when FIFO is non-empty and dato_out is meaningful.
REQ-009 SHALL have port dato_listo  input  1  consumer ready; a pop occurs on a rising edge where dato_valido and dato_listo are both high.
REQ-010 SHALL have port ocupacion  output  clog2(PROFUNDIDAD)+1  number of words stored.
REQ-011 SHALL have port desborde  output  1  sticky overflow flag.
REQ-012 SHALL have port abortos  output  8  saturating count of partial words discarded on sync loss.

Function
REQ-013 SHALL hold FSM states ESPERA (valido low) and ENSAMBLA (collecting bits); ESPERA->ENSAMBLA on an edge with valido=1; ENSAMBLA->ESPERA on an edge with valido=0.
REQ-014 SHALL, on every edge with valido=1, shift s_in into the assembly register and increment the bit counter; the first such edge after ESPERA supplies the MSB.
REQ-015 SHALL, on the edge that samples bit ANCHO-1, complete the word, reset the bit counter to 0 and continue in ENSAMBLA with the next word contiguous (no gap cycle).
REQ-016 SHALL push a completed word into the FIFO on that same edge; dato_valido rises on that edge if the FIFO was empty (latency 0 cycles after the last bit's sampling edge).
REQ-017 SHALL, when valido is sampled 0 with bit counter in 1..ANCHO-1, discard the partial word, clear the counter and increment abortos (saturating at 255); a counter value of 0 SHALL NOT count as an abort.
REQ-018 SHALL, when a word completes while ocupacion=PROFUNDIDAD and no pop occurs that edge, drop the new word, keep the stored contents and set desborde.
REQ-019 SHALL, on simultaneous push and pop, accept the push even when full; ocupacion SHALL remain unchanged.
REQ-020 SHALL present dato_out as the oldest stored word; dato_out SHALL hold its value while dato_listo is low.
REQ-021 SHALL treat read and write pointers as modulo-PROFUNDIDAD counters that wrap without a gap.

Reset
REQ-022 SHALL, while rst=0, force state ESPERA, bit counter 0, assembly register 0, FIFO empty, dato_out=0, dato_valido=0, ocupacion=0, desborde=0, abortos=0.
REQ-023 SHALL, on reset mid-word, discard the partial word without incrementing abortos.
REQ-024 SHALL clear desborde only by reset.

Structure
REQ-025 SHALL place ANCHO, PROFUNDIDAD defaults and state encodings in the shared constants package/include used by the synchronizer stage.
REQ-026 SHALL instantiate one sub-module, fifo_palabras, holding storage, pointers and ocupacion; assembly FSM, abort counter and overflow logic stay in the top.

Verification
REQ-027 SHALL cover: valido=1 for 5 edges with s_in 1,1,0,0,1, dato_listo=0 -> dato_out=5'b11001, dato_valido=1, ocupacion=1 after the 5th edge.
REQ-028 SHALL cover: valido=1 for 3 edges then 0 -> no push, ocupacion=0, abortos=1.
REQ-029 SHALL cover: 4 words 00001,00010,00011,00100 with dato_listo=0, then a 5th word 11111 -> ocupacion=4, desborde=1, dato_out=5'b00001.
REQ-030 SHALL cover: FIFO full, dato_listo=1 on the edge the 5th word completes -> ocupacion=4, desborde=0, last stored word=the 5th word.
REQ-031 SHALL cover: rst pulsed low after 2 bits of a word -> all outputs 0; after release the next 5 in-sync bits form a complete word with abortos=0.
REQ-032 SHALL cover: 10 consecutive valido=1 edges -> exactly 2 pushes on edges 5 and 10, with no lost bits.

Source files
------------

// File: rtl/deserializador_trama_pkg.sv
// Shared constants for the framing chain: default word/FIFO sizes and the
// assembly FSM state encoding used by the synchronizer stage.
package deserializador_trama_pkg;

    localparam int unsigned ANCHO_DEF       = 5;
    localparam int unsigned PROFUNDIDAD_DEF = 4;
    localparam int unsigned ABORTOS_MAX     = 255;

    typedef enum logic {
        Espera   = 1'b0,
        Ensambla = 1'b1
    } estado_t;

endpackage

// File: rtl/deserializador_trama_fifo_palabras.sv
// Word FIFO: circular storage with modulo-depth pointers and an occupancy count.
// Push while full is only issued by the caller together with a pop.
module fifo_palabras #(
    parameter int unsigned ANCHO       = 5,
    parameter int unsigned PROFUNDIDAD = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           escribir,
    input  logic [ANCHO-1:0]               dato_in,
    input  logic                           leer,
    output logic [ANCHO-1:0]               dato_out,
    output logic                           no_vacio,
    output logic                           lleno,
    output logic [$clog2(PROFUNDIDAD):0]   ocupacion
);

    localparam int unsigned PW = $clog2(PROFUNDIDAD);
    localparam int unsigned OW = PW + 1;

    logic [ANCHO-1:0] mem_q [PROFUNDIDAD];
    logic [PW-1:0]    wr_q, rd_q;
    logic [OW-1:0]    cnt_q, cnt_d;

    // Pointers wrap naturally because PROFUNDIDAD is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(PROFUNDIDAD); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (escribir) begin
                mem_q[wr_q] <= dato_in;
                wr_q        <= wr_q + 1'b1;
            end
            if (leer) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({escribir, leer})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    assign no_vacio  = (cnt_q != '0);
    assign lleno     = (cnt_q == OW'(PROFUNDIDAD));
    assign ocupacion = cnt_q;
    assign dato_out  = no_vacio ? mem_q[rd_q] : '0;

endmodule

// File: rtl/deserializador_trama.sv
// Serial-to-parallel framer: assembles MSB-first words while the link is in
// sync, queues them in a word FIFO, counts aborted words and flags overflow.
module deserializador_trama
    import deserializador_trama_pkg::*;
#(
    parameter int unsigned ANCHO       = ANCHO_DEF,
    parameter int unsigned PROFUNDIDAD = PROFUNDIDAD_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_in,
    input  logic                           valido,
    output logic [ANCHO-1:0]               dato_out,
    output logic                           dato_valido,
    input  logic                           dato_listo,
    output logic [$clog2(PROFUNDIDAD):0]   ocupacion,
    output logic                           desborde,
    output logic [7:0]                     abortos
);

    localparam int unsigned CW = $clog2(ANCHO);

    estado_t          estado_q, estado_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ANCHO-1:0] asm_q, asm_d, palabra;
    logic             completa, abortar, pop, lleno, escribir;
    logic             desborde_q;
    logic [7:0]       abortos_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q   <= Espera;
            cnt_q      <= '0;
            asm_q      <= '0;
            desborde_q <= 1'b0;
            abortos_q  <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            if (completa && lleno && !pop) begin
                desborde_q <= 1'b1;
            end
            if (abortar && (abortos_q != 8'(ABORTOS_MAX))) begin
                abortos_q <= abortos_q + 8'd1;
            end
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        completa = 1'b0;
        abortar  = 1'b0;
        palabra  = {asm_q[ANCHO-2:0], s_in};

        unique case (estado_q)
            Espera:   if (valido)  estado_d = Ensambla;
            Ensambla: if (!valido) estado_d = Espera;
            default:  estado_d = Espera;
        endcase

        if (valido) begin
            asm_d = palabra;
            if (cnt_q == CW'(ANCHO - 1)) begin
                completa = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            // A counter of zero means we sit on a word boundary: nothing is lost.
            abortar = (estado_q == Ensambla) && (cnt_q != '0);
            cnt_d   = '0;
            asm_d   = '0;
        end
    end

    assign pop      = dato_valido && dato_listo;
    assign escribir = completa && (!lleno || pop);

    fifo_palabras #(
        .ANCHO       (ANCHO),
        .PROFUNDIDAD (PROFUNDIDAD)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .escribir  (escribir),
        .dato_in   (palabra),
        .leer      (pop),
        .dato_out  (dato_out),
        .no_vacio  (dato_valido),
        .lleno     (lleno),
        .ocupacion (ocupacion)
    );

    assign desborde = desborde_q;
    assign abortos  = abortos_q;

endmodule

// File: tb/tb_deserializador_trama.sv
// Directed and randomized bench for deserializador_trama against a queue-based
// reference model of the framing rules.
module tb_deserializador_trama;
    import deserializador_trama_pkg::*;

    localparam int unsigned W = ANCHO_DEF;
    localparam int unsigned D = PROFUNDIDAD_DEF;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    s_in;
    logic                    valido;
    logic                    dato_listo;
    logic [W-1:0]            dato_out;
    logic                    dato_valido;
    logic [$clog2(D):0]      ocupacion;
    logic                    desborde;
    logic [7:0]              abortos;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int           m_nbits;
    int unsigned  m_acc;
    logic [W-1:0] m_q[$];
    bit           m_des;
    int           m_ab;

    deserializador_trama #(
        .ANCHO       (W),
        .PROFUNDIDAD (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_in        (s_in),
        .valido      (valido),
        .dato_out    (dato_out),
        .dato_valido (dato_valido),
        .dato_listo  (dato_listo),
        .ocupacion   (ocupacion),
        .desborde    (desborde),
        .abortos     (abortos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        logic [W-1:0] head;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        check({ctx, "/dato_valido"}, 32'(dato_valido), 32'(m_q.size() != 0));
        check({ctx, "/dato_out"},    32'(dato_out),    32'(head));
        check({ctx, "/ocupacion"},   32'(ocupacion),   32'(m_q.size()));
        check({ctx, "/desborde"},    32'(desborde),    32'(m_des));
        check({ctx, "/abortos"},     32'(abortos),     32'(m_ab));
    endtask

    task automatic model_reset();
        m_nbits = 0;
        m_acc   = 0;
        m_q.delete();
        m_des   = 1'b0;
        m_ab    = 0;
    endtask

    // One clock edge of the framing rules, evaluated with pre-edge values.
    task automatic model_edge(input bit v, input bit s, input bit l);
        bit           pop;
        bit           done;
        logic [W-1:0] w;
        pop  = (m_q.size() != 0) && l;
        done = 1'b0;
        w    = '0;
        if (!v) begin
            if (m_nbits != 0 && m_ab < 255) m_ab++;
            m_nbits = 0;
            m_acc   = 0;
        end else begin
            m_acc = (m_acc * 2 + int'(s)) % (1 << W);
            m_nbits++;
            if (m_nbits == int'(W)) begin
                done    = 1'b1;
                w       = W'(m_acc);
                m_nbits = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (done) begin
            if (m_q.size() < int'(D)) m_q.push_back(w);
            else m_des = 1'b1;
        end
    endtask

    task automatic step(input bit v, input bit s, input bit l, input string ctx);
        valido     = v;
        s_in       = s;
        dato_listo = l;
        model_edge(v, s, l);
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit l_last, input string ctx);
        for (int i = int'(W) - 1; i >= 0; i--) begin
            step(1'b1, w[i], (i == 0) ? l_last : 1'b0, ctx);
        end
    endtask

    task automatic drain(input string ctx);
        for (int i = 0; i < int'(D) + 1; i++) step(1'b0, 1'b0, 1'b1, ctx);
    endtask

    // Asserted just after an edge, so outputs must clear asynchronously.
    task automatic do_reset(input string ctx);
        rst = 1'b0;
        #2;
        model_reset();
        check_all(ctx);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        valido     = 1'b0;
        s_in       = 1'b0;
        dato_listo = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_inicial");
        rst = 1'b1;

        // Single word 11001, consumer stalled
        send_word(5'b11001, 1'b0, "palabra_11001");
        check("req027_dato_out", 32'(dato_out), 32'(5'b11001));
        check("req027_ocupacion", 32'(ocupacion), 32'd1);
        step(1'b0, 1'b0, 1'b0, "limite_sin_aborto");
        drain("drenaje_1");

        // Sync lost after 3 bits
        step(1'b1, 1'b1, 1'b0, "parcial");
        step(1'b1, 1'b0, 1'b0, "parcial");
        step(1'b1, 1'b1, 1'b0, "parcial");
        step(1'b0, 1'b0, 1'b0, "aborto");
        check("req028_abortos", 32'(abortos), 32'd1);
        check("req028_ocupacion", 32'(ocupacion), 32'd0);

        // Fill then overflow
        send_word(5'b00001, 1'b0, "lleno");
        send_word(5'b00010, 1'b0, "lleno");
        send_word(5'b00011, 1'b0, "lleno");
        send_word(5'b00100, 1'b0, "lleno");
        send_word(5'b11111, 1'b0, "desborde");
        check("req029_desborde", 32'(desborde), 32'd1);
        check("req029_dato_out", 32'(dato_out), 32'(5'b00001));
        step(1'b0, 1'b0, 1'b0, "desborde_pegajoso");
        drain("drenaje_2");
        check("req024_desborde_pegajoso", 32'(desborde), 32'd1);

        // Full with simultaneous pop and push
        do_reset("reset_2");
        send_word(5'b00001, 1'b0, "lleno_pop");
        send_word(5'b00010, 1'b0, "lleno_pop");
        send_word(5'b00011, 1'b0, "lleno_pop");
        send_word(5'b00100, 1'b0, "lleno_pop");
        send_word(5'b11111, 1'b1, "push_pop");
        check("req030_ocupacion", 32'(ocupacion), 32'd4);
        check("req030_desborde", 32'(desborde), 32'd0);
        check("req030_cabeza", 32'(dato_out), 32'(5'b00010));
        drain("drenaje_3");

        // Reset in the middle of a word
        step(1'b1, 1'b1, 1'b0, "medio");
        step(1'b1, 1'b0, 1'b0, "medio");
        do_reset("reset_medio");
        send_word(5'b10110, 1'b0, "tras_reset");
        check("req031_abortos", 32'(abortos), 32'd0);
        check("req031_dato_out", 32'(dato_out), 32'(5'b10110));
        drain("drenaje_4");

        // Ten contiguous in-sync edges
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, "contiguo");
        end
        check("req032_ocupacion", 32'(ocupacion), 32'd2);
        step(1'b0, 1'b0, 1'b0, "contiguo_fin");
        drain("drenaje_5");

        // Abort counter saturation
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 1'b1, 1'b0, "saturacion");
            step(1'b0, 1'b0, 1'b0, "saturacion");
        end
        check("abortos_saturado", 32'(abortos), 32'd255);

        // Random traffic
        do_reset("reset_3");
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), "aleatorio");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
